// File: rtl/seg_scan_driver.sv
// Multi-digit 7-segment driver: scanned and static outputs,
// shadowed tear-free updates, blink and leading-zero suppression.
module seg_scan_driver #(
    parameter int N         = 8,
    parameter int DIV       = 1000,
    parameter int BLINK_DIV = 256,
    parameter int LZS       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [4*N-1:0]   din,
    input  logic [N-1:0]     dp_in,
    input  logic [N-1:0]     en_in,
    input  logic [N-1:0]     blink_in,
    output logic             busy,
    output logic [N-1:0]     an,
    output logic [7:0]       seg,
    output logic [8*N-1:0]   seg_all
);

    localparam int PW = $clog2(DIV);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

    logic [PW-1:0]  r_pre;
    logic [IW-1:0]  r_idx;
    logic [BW-1:0]  r_bcnt;
    logic           r_phase;

    logic [4*N-1:0] r_sh_din;
    logic [N-1:0]   r_sh_dp;
    logic [N-1:0]   r_sh_en;
    logic [N-1:0]   r_sh_bl;
    logic [4*N-1:0] r_din;
    logic [N-1:0]   r_dp;
    logic [N-1:0]   r_en;
    logic [N-1:0]   r_bl;
    logic           r_busy;

    logic [N-1:0]   r_an;
    logic [7:0]     r_seg;
    logic [8*N-1:0] r_seg_all;

    logic           w_tick;
    logic           w_wrap;
    logic [N-1:0]   w_supp;
    logic [N-1:0]   w_an;
    logic [7:0]     w_dig [N];
    logic [8*N-1:0] w_all;

    function automatic logic [7:0] glyph(input logic [3:0] h);
        logic [7:0] g;
        case (h)
            4'h0:    g = 8'hFC;
            4'h1:    g = 8'h60;
            4'h2:    g = 8'hDA;
            4'h3:    g = 8'hF2;
            4'h4:    g = 8'h66;
            4'h5:    g = 8'hB6;
            4'h6:    g = 8'hBE;
            4'h7:    g = 8'hE0;
            4'h8:    g = 8'hFE;
            4'h9:    g = 8'hF6;
            4'hA:    g = 8'hEE;
            4'hB:    g = 8'h3E;
            4'hC:    g = 8'h9C;
            4'hD:    g = 8'h7A;
            4'hE:    g = 8'h9E;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    assign w_tick = (r_pre == PRE_MAX);
    assign w_wrap = w_tick && (r_idx == IDX_MAX);

    // Prescaler and scan index: one scan step every DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick)
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end
    end

    // Blink phase flips after every BLINK_DIV scan steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_bcnt == BLK_MAX) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    // Shadow capture on load; commit only at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_din <= '0;
            r_sh_dp  <= '0;
            r_sh_en  <= '0;
            r_sh_bl  <= '0;
            r_din    <= '0;
            r_dp     <= '0;
            r_en     <= '0;
            r_bl     <= '0;
            r_busy   <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_din <= r_sh_din;
                r_dp  <= r_sh_dp;
                r_en  <= r_sh_en;
                r_bl  <= r_sh_bl;
            end
            if (load) begin
                r_sh_din <= din;
                r_sh_dp  <= dp_in;
                r_sh_en  <= en_in;
                r_sh_bl  <= blink_in;
                r_busy   <= 1'b1;
            end else if (w_wrap) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Per-digit glyphs with blanking and leading-zero suppression
    always_comb begin : decode
        logic       v_run;
        logic       v_blank;
        logic [7:0] v_g;
        w_supp = '0;
        w_all  = '0;
        v_run  = 1'b1;
        for (int i = N - 1; i >= 1; i--) begin
            v_run     = v_run && (r_din[4*i +: 4] == 4'h0) && !r_dp[i];
            w_supp[i] = (LZS != 0) && v_run;
        end
        for (int i = 0; i < N; i++) begin
            v_g      = glyph(r_din[4*i +: 4]);
            v_g[0]   = r_dp[i];
            v_blank  = !r_en[i] || (r_bl[i] && r_phase) || w_supp[i];
            w_dig[i] = v_blank ? 8'hFF : ~v_g;
            w_all[8*i +: 8] = w_dig[i];
            w_an[i]  = (r_idx != IW'(i));
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an      <= '1;
            r_seg     <= 8'hFF;
            r_seg_all <= '1;
        end else begin
            r_an      <= w_an;
            r_seg     <= w_dig[r_idx];
            r_seg_all <= w_all;
        end
    end

    assign busy    = r_busy;
    assign an      = r_an;
    assign seg     = r_seg;
    assign seg_all = r_seg_all;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a time-based display model checks
// every cycle of table, corner-case and random stimulus.
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int DV = 4;
    localparam int BD = 2;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic [3:0]  en_in;
    logic [3:0]  blink_in;
    logic        busy0, busy1;
    logic [3:0]  an0, an1;
    logic [7:0]  seg0, seg1;
    logic [31:0] all0, all1;

    seg_scan_driver #(.N(N), .DIV(DV), .BLINK_DIV(BD), .LZS(0)) u0 (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din),
        .dp_in(dp_in), .en_in(en_in), .blink_in(blink_in),
        .busy(busy0), .an(an0), .seg(seg0), .seg_all(all0)
    );

    seg_scan_driver #(.N(N), .DIV(DV), .BLINK_DIV(BD), .LZS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din),
        .dp_in(dp_in), .en_in(en_in), .blink_in(blink_in),
        .busy(busy1), .an(an1), .seg(seg1), .seg_all(all1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] GLY [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    // model: cycles since reset release plus shadow/display contents
    int          c;
    logic [15:0] m_sh_din, m_din;
    logic [3:0]  m_sh_dp, m_sh_en, m_sh_bl;
    logic [3:0]  m_dp, m_en, m_bl;
    logic        m_busy;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_all(input bit lzs, input int ph);
        logic [31:0] r;
        logic [7:0]  g;
        bit          supp, blank;
        r = '0;
        for (int i = 0; i < N; i++) begin
            supp = lzs && (i > 0);
            for (int j = i; j < N; j++)
                if (m_din[4*j +: 4] != 0 || m_dp[j]) supp = 0;
            blank = !m_en[i] || (m_bl[i] && ph == 1) || supp;
            g = GLY[m_din[4*i +: 4]];
            g[0] = m_dp[i];
            r[8*i +: 8] = blank ? 8'hFF : ~g;
        end
        return r;
    endfunction

    function automatic bit next_is_wrap();
        return (c % DV == DV - 1) && ((c / DV) % N == N - 1);
    endfunction

    task automatic model_reset();
        c = 0;
        m_sh_din = '0; m_sh_dp = '0; m_sh_en = '0; m_sh_bl = '0;
        m_din = '0; m_dp = '0; m_en = '0; m_bl = '0;
        m_busy = 0;
    endtask

    task automatic step();
        int          t, idx, ph;
        bit          wrap;
        logic [31:0] e0, e1;
        logic [3:0]  ean;
        t    = c / DV;
        idx  = t % N;
        ph   = (t / BD) % 2;
        wrap = next_is_wrap();
        e0   = model_all(0, ph);
        e1   = model_all(1, ph);
        ean  = ~(4'b0001 << idx);
        @(posedge clk);
        #1;
        if (wrap) begin
            m_din = m_sh_din; m_dp = m_sh_dp;
            m_en  = m_sh_en;  m_bl = m_sh_bl;
        end
        if (load) begin
            m_sh_din = din; m_sh_dp = dp_in;
            m_sh_en  = en_in; m_sh_bl = blink_in;
            m_busy = 1;
        end else if (wrap) begin
            m_busy = 0;
        end
        c++;
        check("an0", an0, ean);
        check("an1", an1, ean);
        check("seg0", seg0, e0[8*idx +: 8]);
        check("seg1", seg1, e1[8*idx +: 8]);
        check("seg_all0", all0, e0);
        check("seg_all1", all1, e1);
        check("busy0", busy0, m_busy);
        check("busy1", busy1, m_busy);
    endtask

    task automatic check_blank(input string nm);
        check({nm, "_an"}, {an1, an0}, 8'hFF);
        check({nm, "_seg"}, {seg1, seg0}, 16'hFFFF);
        check({nm, "_all0"}, all0, 32'hFFFF_FFFF);
        check({nm, "_all1"}, all1, 32'hFFFF_FFFF);
        check({nm, "_busy"}, {busy1, busy0}, 2'b00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_blank("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic load_vec(input logic [15:0] d, input logic [3:0] p,
                            input logic [3:0] e, input logic [3:0] b);
        din = d; dp_in = p; en_in = e; blink_in = b;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_commit();
        int n;
        n = 0;
        while (busy0 && n < 40) begin
            step();
            n++;
        end
        check("commit_timeout", n < 40, 1);
        step();
    endtask

    typedef struct {
        logic [15:0] din;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [31:0] x0;
        logic [31:0] x1;
    } vec_t;

    vec_t tbl [8];
    int   n_ff, n_on;

    initial begin
        tbl[0] = '{16'h1A2F, 4'b0100, 4'hF, 32'h9F10_2571, 32'h9F10_2571};
        tbl[1] = '{16'h0050, 4'b0000, 4'hF, 32'h0303_4903, 32'hFFFF_4903};
        tbl[2] = '{16'h0000, 4'b0000, 4'hF, 32'h0303_0303, 32'hFFFF_FF03};
        tbl[3] = '{16'h0000, 4'b0100, 4'hF, 32'h0302_0303, 32'hFF02_0303};
        tbl[4] = '{16'h89BC, 4'b0000, 4'b0101, 32'hFF09_FF63, 32'hFF09_FF63};
        tbl[5] = '{16'h3E7D, 4'b1001, 4'hF, 32'h0C61_1F84, 32'h0C61_1F84};
        tbl[6] = '{16'h46B0, 4'b0000, 4'hF, 32'h9941_C103, 32'h9941_C103};
        tbl[7] = '{16'h0008, 4'b0000, 4'hF, 32'h0303_0301, 32'hFFFF_FF01};

        rst_n = 1'b0; load = 1'b0;
        din = '0; dp_in = '0; en_in = '0; blink_in = '0;
        model_reset();
        do_reset();

        // blank until first commit, an walks E,D,B,7
        repeat (20) step();

        foreach (tbl[k]) begin
            load_vec(tbl[k].din, tbl[k].dp, tbl[k].en, 4'b0000);
            wait_commit();
            check("tbl_all0", all0, tbl[k].x0);
            check("tbl_all1", all1, tbl[k].x1);
        end

        // two loads before one commit: last write wins
        step();
        load_vec(16'h1234, 4'b0000, 4'hF, 4'b0000);
        step();
        load_vec(16'h5678, 4'b0000, 4'hF, 4'b0000);
        check("tear_busy", busy0, 1);
        wait_commit();
        check("tear_all", all0, 32'h4941_1F01);

        // load on the commit edge
        load_vec(16'h1111, 4'b0000, 4'hF, 4'b0000);
        wait_commit();
        load_vec(16'h2222, 4'b0000, 4'hF, 4'b0000);
        for (int n = 0; n < 40 && !next_is_wrap(); n++) step();
        check("edge_align", next_is_wrap(), 1);
        load_vec(16'h3333, 4'b0000, 4'hF, 4'b0000);
        check("edge_busy", busy0, 1);
        step();
        check("edge_old", all0, 32'h2525_2525);
        wait_commit();
        check("edge_new", all0, 32'h0D0D_0D0D);

        // blink digit 0 only
        load_vec(16'h0000, 4'b0000, 4'hF, 4'b0001);
        wait_commit();
        n_ff = 0; n_on = 0;
        repeat (40) begin
            step();
            if (all0[7:0] == 8'hFF) n_ff++;
            if (all0[7:0] == 8'h03) n_on++;
            check("blink_steady", all0[31:8], 24'h030303);
        end
        check("blink_toggles", {n_ff > 0, n_on > 0}, 2'b11);

        // mid-operation reset blanks at once
        load_vec(16'hFFFF, 4'b0000, 4'hF, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        check_blank("async_rst");
        do_reset();
        repeat (8) step();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            din      = 16'($urandom);
            if ($urandom_range(0, 1) == 1) din[15:8] = 8'h00;
            if ($urandom_range(0, 3) == 0) din[7:4] = 4'h0;
            dp_in    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            en_in    = 4'($urandom) | 4'b1000;
            blink_in = 4'($urandom);
            load     = ($urandom_range(0, 7) == 0);
            step();
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised successor to the single-digit hex-to-7-segment decoder.
- Drives N digits from a packed hex word, with per-digit decimal point, enable, blink and optional leading-zero suppression.
- Provides two display paths: time-multiplexed (one digit select plus a shared segment bus) for scanned displays, and static per-digit segment outputs for the NVBoard 8-digit bank.
- Sits between core/debug logic and the board segment pins.

Parameters:
- N, 8, number of digits (1..8).
- DIV, 1000, clk cycles per scan step (>=2).
- BLINK_DIV, 256, scan steps per blink half-period (>=1).
- LZS, 0, 1 = suppress leading zeros (digit N-1 downward; digit 0 is never suppressed).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  one-cycle strobe; captures din/dp_in/en_in/blink_in
- din  in  4*N  hex nibbles; digit i = din[4i+3:4i]
- dp_in  in  N  decimal point per digit, 1 = lit
- en_in  in  N  digit enable, 1 = shown
- blink_in  in  N  1 = digit blinks
- busy  out  1  pending shadow data not yet committed
- an  out  N  scanned digit select, active-low one-hot
- seg  out  8  scanned segments, active-low, bit7..bit0 = a,b,c,d,e,f,g,dp
- seg_all  out  8*N  static segments, digit i = seg_all[8i+7:8i], active-low

Behaviour:
- Glyphs (active-high, before inversion; dp bit 0):
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6
  - A=EE, b=3E, C=9C, d=7A, E=9E, F=8E
  - Bit 0 is replaced by dp.
  - Output = bitwise NOT of the glyph.
- Reset (async, while rst_n=0):
  - All registers cleared.
  - an = all 1, seg = 8'hFF, seg_all = all 1, busy = 0.
  - Scan index = 0, prescaler = 0, blink phase = 0.
  - Display and shadow registers = 0; en = 0, so all digits are blank.
- Load:
  - load=1 at a rising edge copies din/dp_in/en_in/blink_in into the shadow register and sets busy the next cycle.
  - A later load before commit overwrites the shadow; last write wins.
- Commit:
  - Shadow is copied to the display register at the scan-step edge where the index wraps N-1 -> 0 (frame boundary), so a frame never tears.
  - busy clears on the same edge.
  - If load coincides with that commit edge, the new data goes to the shadow and busy stays 1; the old shadow is committed.
  - For N=1, every scan step is a frame boundary.
- Prescaler:
  - Counts 0..DIV-1, then wraps.
  - tick = (count == DIV-1).
  - On tick, index = (index+1) mod N.
- Blink:
  - A counter of ticks toggles the blink phase every BLINK_DIV ticks.
  - A digit with blink=1 is blanked while phase = 1.
- Blanking:
  - A digit is blanked when en=0, when it blinks in the off phase, or when it is suppressed by LZS.
  - A blanked digit outputs 8'hFF, dp included.
- LZS=1: digit i>0 is suppressed when its nibble and all higher nibbles are 0 and their dp bits are 0. Suppression is computed from the display register only.
- Outputs:
  - an, seg and seg_all are registered and update one cycle after the state that produced them.
  - an[index] = 0 and seg = the glyph of digit index.
  - seg_all reflects the display register for all digits simultaneously, with the same blanking, and does not depend on the scan.
  - A disabled digit still gets its an slot; its seg is 8'hFF.
- Width rules:
  - Prescaler width = clog2(DIV).
  - Index width = max(1, clog2(N)).
  - Blink counter width = max(1, clog2(BLINK_DIV)).
  - No overflow beyond the mod wraps.
- Mid-operation reset returns to the reset state immediately; any shadow data is lost.

Test Plan:
- Reset: rst_n=0 for 3 cycles, deassert -> an=8'hFF, seg=8'hFF, seg_all all 1, busy=0, and all remain blank until the first commit.
- Decode (N=4, DIV=4, LZS=0): load din=16'h1A2F, en=4'hF, dp=4'b0100 -> after commit, seg_all digit0=~8E=71, digit1=~DA=25, digit2=~EF=10, digit3=~60=9F; an cycles E,D,B,7 every 4 cycles.
- Tear-free commit: load 16'h1234 mid-frame, then 16'h5678 two cycles later -> busy=1 until the wrap, first committed frame shows 5678, and no frame mixes digits from the two loads.
- Load on commit edge: assert load exactly on the wrap tick -> the old shadow is committed, busy stays 1, and the new value appears one frame later.
- LZS=1: din=16'h0050 -> digits 3 and 2 blank (FF), digit1=~B6=49, digit0=~FC=03; din=16'h0000 -> only digit0 shows 03.
- Blink (BLINK_DIV=2): blink=4'b0001, en=4'hF -> digit0 alternates glyph/FF every 2 ticks in both seg and seg_all, and the other digits stay steady; a mid-blink reset blanks everything immediately.
